// File: rtl/tff_updown_counter_pkg.sv
// rtl/tff_updown_counter_pkg.sv - shared constants and helpers for T-flop counters
//
// Purpose: mode encoding for the SATURATE parameter and the load clamp helper
//          shared by the up/down counter and the timer blocks built on it.
// Ports:   none (package).

package tff_updown_counter_pkg;

  // SATURATE parameter encoding
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Working width of clamp_load; callers zero-extend into it.
  localparam int CLAMP_W = 32;

  // Out-of-range load values are pinned to the top of the count range.
  function automatic logic [CLAMP_W-1:0] clamp_load(
    input logic [CLAMP_W-1:0] load_val,
    input logic [CLAMP_W-1:0] max_val
  );
    return (load_val > max_val) ? max_val : load_val;
  endfunction

endpackage

// File: rtl/tff_updown_counter_tff_cell.sv
// rtl/tff_updown_counter_tff_cell.sv - single toggle flip-flop storage cell
//
// Purpose: one count bit. Synchronous reset loads rst_val; otherwise the bit
//          inverts on every rising edge where T is high.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   rst_val - value taken by q while rst is high
//   T       - toggle request
//   q       - stored bit

module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic T,
  output logic q
);

  // rst is tested first so an unknown T during reset cannot reach q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (T) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_updown_counter.sv
// rtl/tff_updown_counter.sv - parametrised up/down counter built from T-flop cells
//
// Purpose: synchronous up/down counter over 0..MAX_VAL with wrap or saturate
//          behaviour, synchronous load (clamped), count enable, combinational
//          terminal-count flag for cascading and a registered wrap pulse.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (q <= RESET_VAL, wrap <= 0)
//   en       - count enable
//   up       - 1 = increment, 0 = decrement
//   load     - synchronous load strobe (beats en)
//   load_val - value captured on load, clamped to MAX_VAL
//   q        - current count
//   tc       - en & (up ? q == MAX_VAL : q == 0)
//   wrap     - one-cycle pulse coincident with the wrapped q value

module tff_updown_counter
  import tff_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int SATURATE  = MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_Q = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CLAMP_W-1:0] load_clamped;
  logic [WIDTH-1:0]   load_q;
  logic [WIDTH-1:0]   q_n;
  logic [WIDTH-1:0]   toggle;
  logic               wrap_n;
  logic               at_max;
  logic               at_zero;

  assign load_clamped = clamp_load(CLAMP_W'(load_val), CLAMP_W'(MAX_VAL));
  // The clamp result never exceeds MAX_VAL, so it always fits in WIDTH bits.
  assign load_q = load_clamped[WIDTH-1:0];

  generate
    if (WIDTH < CLAMP_W) begin : g_clamp_hi
      logic unused_clamp_hi;
      assign unused_clamp_hi = |load_clamped[CLAMP_W-1:WIDTH];
    end
  endgenerate

  // Exact compares keep non-power-of-two ranges (e.g. BCD) inside 0..MAX_VAL.
  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

  assign tc = en & (up ? at_max : at_zero);

  // Next-count selection. Reset is not handled here: the cells apply it
  // directly, which keeps unknown control inputs away from the state.
  always_comb begin
    q_n    = q;
    wrap_n = 1'b0;
    if (load) begin
      q_n = load_q;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          q_n = q + ONE_Q;
        end else if (SATURATE != MODE_SAT) begin
          q_n    = '0;
          wrap_n = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_n = q - ONE_Q;
        end else if (SATURATE != MODE_SAT) begin
          q_n    = MAX_Q;
          wrap_n = 1'b1;
        end
      end
    end
  end

  // A bit toggles exactly when its next value differs from its current one.
  assign toggle = q ^ q_n;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RST_Q[i]),
        .T       (toggle[i]),
        .q       (q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb/tb_tff_updown_counter.sv - self-checking bench for tff_updown_counter

module tb_tff_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instances: 0 = BCD wrap (4b, max 9), 1 = saturating 4b, 2 = default 8b
  logic       rst_s [3];
  logic       en_s  [3];
  logic       up_s  [3];
  logic       ld_s  [3];
  logic [7:0] lv_s  [3];
  logic       tc_s  [3];
  logic       wr_s  [3];
  logic [3:0] q0, q1;
  logic [7:0] q2;

  // Cascaded BCD pair
  logic       c_rst, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wr, hi_wr;

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0)) u_bcd (
    .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .up(up_s[0]), .load(ld_s[0]),
    .load_val(lv_s[0][3:0]), .q(q0), .tc(tc_s[0]), .wrap(wr_s[0]));

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1), .RESET_VAL(0)) u_sat (
    .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .up(up_s[1]), .load(ld_s[1]),
    .load_val(lv_s[1][3:0]), .q(q1), .tc(tc_s[1]), .wrap(wr_s[1]));

  tff_updown_counter u_w8 (
    .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .up(up_s[2]), .load(ld_s[2]),
    .load_val(lv_s[2]), .q(q2), .tc(tc_s[2]), .wrap(wr_s[2]));

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0)) u_lo (
    .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wr));

  tff_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0)) u_hi (
    .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wr));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  maxv [3] = '{9, 15, 255};
  bit  satv [3] = '{1'b0, 1'b1, 1'b0};
  int  mq   [3] = '{0, 0, 0};
  bit  mw   [3] = '{1'b0, 1'b0, 1'b0};
  bit  mval [3] = '{1'b0, 1'b0, 1'b0};
  int  nq;
  bit  nw;
  int  cm     = 0;   // cascade value as a decimal number 0..99
  bit  chw    = 1'b0;
  bit  cvalid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      nw = 1'b0;
      if (rst_s[k]) begin
        nq = 0;
        mval[k] = 1'b1;
      end else if (ld_s[k]) begin
        nq = (int'(lv_s[k]) > maxv[k]) ? maxv[k] : int'(lv_s[k]);
      end else if (en_s[k] && up_s[k]) begin
        if (satv[k] && mq[k] == maxv[k]) nq = mq[k];
        else begin
          nq = (mq[k] + 1) % (maxv[k] + 1);
          nw = (mq[k] == maxv[k]);
        end
      end else if (en_s[k]) begin
        if (satv[k] && mq[k] == 0) nq = 0;
        else begin
          nq = (mq[k] + maxv[k]) % (maxv[k] + 1);
          nw = (mq[k] == 0);
        end
      end else begin
        nq = mq[k];
      end
      mq[k] = nq;
      mw[k] = nw;
    end
    if (c_rst) begin
      cm = 0; chw = 1'b0; cvalid = 1'b1;
    end else begin
      chw = c_en && (cm == 99);
      if (c_en) cm = (cm + 1) % 100;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int dq [3];
    dq[0] = int'(q0); dq[1] = int'(q1); dq[2] = int'(q2);
    for (int k = 0; k < 3; k++) begin
      if (mval[k]) begin
        chk($sformatf("model_q%0d", k), dq[k], mq[k]);
        chk($sformatf("model_tc%0d", k), int'(tc_s[k]),
            int'(en_s[k] && (up_s[k] ? (mq[k] == maxv[k]) : (mq[k] == 0))));
        chk($sformatf("model_wrap%0d", k), int'(wr_s[k]), int'(mw[k]));
      end
    end
    if (cvalid) begin
      chk("model_cascade", int'({hi_q, lo_q}), (cm / 10) * 16 + (cm % 10));
      chk("model_hi_wrap", int'(hi_wr), int'(chw));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int exp_dn [3] = '{0, 9, 8};
  int exp_dw [3] = '{0, 1, 0};
  int hw_cnt;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; en_s[k] = 1'b0; up_s[k] = 1'b1; ld_s[k] = 1'b0; lv_s[k] = 8'd0;
    end
    c_rst = 1'b1; c_en = 1'b0;
    cyc(2);
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    c_rst = 1'b0;
    chk("rst_q0", int'(q0), 0);
    chk("rst_q2", int'(q2), 0);
    chk("rst_wrap0", int'(wr_s[0]), 0);

    // BCD up-count with wrap
    en_s[0] = 1'b1; up_s[0] = 1'b1;
    #1;
    chk("bcd_tc_start", int'(tc_s[0]), 0);
    for (int i = 1; i <= 11; i++) begin
      cyc(1);
      chk("bcd_q", int'(q0), i % 10);
      chk("bcd_wrap", int'(wr_s[0]), int'(i == 10));
      chk("bcd_tc", int'(tc_s[0]), int'((i % 10) == 9));
    end
    en_s[0] = 1'b0;

    // down wrap
    ld_s[0] = 1'b1; lv_s[0] = 8'd1;
    cyc(1);
    ld_s[0] = 1'b0;
    chk("down_load_q", int'(q0), 1);
    en_s[0] = 1'b1; up_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("down_q", int'(q0), exp_dn[i]);
      chk("down_wrap", int'(wr_s[0]), exp_dw[i]);
      chk("down_tc", int'(tc_s[0]), int'(i == 0));
    end
    en_s[0] = 1'b0;

    // saturate
    ld_s[1] = 1'b1; lv_s[1] = 8'd14;
    cyc(1);
    ld_s[1] = 1'b0;
    chk("sat_load_q", int'(q1), 14);
    en_s[1] = 1'b1; up_s[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("sat_up_q", int'(q1), 15);
      chk("sat_up_wrap", int'(wr_s[1]), 0);
    end
    en_s[1] = 1'b0;
    ld_s[1] = 1'b1; lv_s[1] = 8'd1;
    cyc(1);
    ld_s[1] = 1'b0;
    chk("sat_load1_q", int'(q1), 1);
    en_s[1] = 1'b1; up_s[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("sat_dn_q", int'(q1), 0);
      chk("sat_dn_wrap", int'(wr_s[1]), 0);
    end
    en_s[1] = 1'b0;

    // priority and clamp
    ld_s[0] = 1'b1; lv_s[0] = 8'd7;
    cyc(1);
    chk("prio_pre_q", int'(q0), 7);
    rst_s[0] = 1'b1; lv_s[0] = 8'd5; en_s[0] = 1'b1; up_s[0] = 1'b1;
    cyc(1);
    chk("prio_rst_q", int'(q0), 0);
    rst_s[0] = 1'b0; lv_s[0] = 8'd13;
    cyc(1);
    chk("clamp_q", int'(q0), 9);
    chk("clamp_wrap", int'(wr_s[0]), 0);
    ld_s[0] = 1'b0; en_s[0] = 1'b0;

    // 8-bit mid-count reset and direction flip
    ld_s[2] = 1'b1; lv_s[2] = 8'h7E;
    cyc(1);
    ld_s[2] = 1'b0;
    chk("w8_load_q", int'(q2), 8'h7E);
    en_s[2] = 1'b1; up_s[2] = 1'b1;
    cyc(1); chk("w8_q_7f", int'(q2), 8'h7F);
    cyc(1); chk("w8_q_80", int'(q2), 8'h80);
    up_s[2] = 1'b0;
    cyc(1); chk("w8_flip_q", int'(q2), 8'h7F);
    rst_s[2] = 1'b1;
    cyc(1); chk("w8_rst_q", int'(q2), 0);
    rst_s[2] = 1'b0; up_s[2] = 1'b1;
    cyc(1); chk("w8_resume_q", int'(q2), 1);
    ld_s[2] = 1'b1; lv_s[2] = 8'hFF;
    cyc(1);
    ld_s[2] = 1'b0;
    chk("w8_load_ff", int'(q2), 255);
    chk("w8_tc_ff", int'(tc_s[2]), 1);
    cyc(1);
    chk("w8_wrap_q", int'(q2), 0);
    chk("w8_wrap", int'(wr_s[2]), 1);
    en_s[2] = 1'b0;

    // cascade 00..99..00
    hw_cnt = 0;
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (hi_wr) hw_cnt++;
      if (i == 45) chk("cascade_45", int'({hi_q, lo_q}), 8'h45);
      if (i == 99) chk("cascade_99", int'({hi_q, lo_q}), 8'h99);
    end
    c_en = 1'b0;
    chk("cascade_end", int'({hi_q, lo_q}), 0);
    chk("cascade_hi_wraps", hw_cnt, 1);

    cyc(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
